// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller valid/ready port between
// NPORTS requesters; one transaction in flight, all outputs registered.
module sdram_arbiter #(
  parameter int NPORTS = 3,
  parameter int ADDR_W = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        p_valid,
  input  logic [NPORTS*ADDR_W-1:0] p_addr,
  input  logic [NPORTS*32-1:0]     p_din,
  input  logic [NPORTS*4-1:0]      p_wmask,
  output logic [NPORTS-1:0]        p_ready,
  output logic [31:0]              p_dout,
  output logic [NPORTS-1:0]        grant,
  output logic                     mem_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_din,
  output logic [3:0]               mem_wmask,
  input  logic [31:0]              mem_dout,
  input  logic                     mem_ready
);

  localparam int LW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [NPORTS-1:0] ONE = {{(NPORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              r_state;
  logic [LW-1:0]       r_last;
  logic [NPORTS-1:0]   r_p_ready;
  logic [NPORTS-1:0]   r_grant;
  logic [31:0]         r_p_dout;
  logic                r_mem_valid;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_din;
  logic [3:0]          r_mem_wmask;

  logic                w_hi_any;
  logic                w_lo_any;
  logic [LW-1:0]       w_hi;
  logic [LW-1:0]       w_lo;
  logic [LW-1:0]       w_win;
  logic                w_any;

  // Search from last+1 upward first; only if nothing above last is requesting
  // does the lowest index at or below last win, giving modulo-NPORTS wrap.
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi     = '0;
    w_lo     = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (p_valid[i]) begin
        if (LW'(i) > r_last) begin
          if (!w_hi_any) begin
            w_hi_any = 1'b1;
            w_hi     = LW'(i);
          end
        end else if (!w_lo_any) begin
          w_lo_any = 1'b1;
          w_lo     = LW'(i);
        end
      end
    end
  end

  assign w_any = |p_valid;
  assign w_win = w_hi_any ? w_hi : w_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= LW'(NPORTS - 1);
      r_p_ready   <= '0;
      r_grant     <= '0;
      r_p_dout    <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_mem_wmask <= '0;
    end else begin
      r_p_ready <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last      <= w_win;
            r_grant     <= ONE << w_win;
            r_mem_addr  <= p_addr[w_win*ADDR_W +: ADDR_W];
            r_mem_din   <= p_din[w_win*32 +: 32];
            r_mem_wmask <= p_wmask[w_win*4 +: 4];
            r_mem_valid <= 1'b1;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_p_dout    <= mem_dout;
            r_p_ready   <= ONE << r_last;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_grant <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p_ready   = r_p_ready;
  assign p_dout    = r_p_dout;
  assign grant     = r_grant;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_sdram_arbiter;
  localparam int NP = 3;
  localparam int AW = 25;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     p_valid;
  logic [NP*AW-1:0]  p_addr;
  logic [NP*32-1:0]  p_din;
  logic [NP*4-1:0]   p_wmask;
  logic [NP-1:0]     p_ready;
  logic [31:0]       p_dout;
  logic [NP-1:0]     grant;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_din;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_dout;
  logic              mem_ready;

  logic [AW-1:0] a_q [NP];
  logic [31:0]   d_q [NP];
  logic [3:0]    m_q [NP];

  sdram_arbiter #(.NPORTS(NP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .p_valid(p_valid), .p_addr(p_addr), .p_din(p_din),
    .p_wmask(p_wmask), .p_ready(p_ready), .p_dout(p_dout), .grant(grant),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wmask(mem_wmask), .mem_dout(mem_dout), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    p_addr  = '0;
    p_din   = '0;
    p_wmask = '0;
    for (int i = 0; i < NP; i++) begin
      p_addr[i*AW +: AW] = a_q[i];
      p_din[i*32 +: 32]  = d_q[i];
      p_wmask[i*4 +: 4]  = m_q[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which port is in service, which just completed.
  int            m_serve = -1;
  int            m_done  = -1;
  int            m_last  = NP - 1;
  logic [AW-1:0] m_addr  = '0;
  logic [31:0]   m_din   = '0;
  logic [3:0]    m_wmask = '0;
  logic [31:0]   m_dout  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_serve = -1; m_done = -1; m_last = NP - 1;
      m_addr = '0; m_din = '0; m_wmask = '0; m_dout = '0;
    end else if (m_done >= 0) begin
      m_done = -1;
    end else if (m_serve >= 0) begin
      if (mem_ready) begin
        m_done  = m_serve;
        m_serve = -1;
        m_dout  = mem_dout;
      end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (p_valid[p]) begin
          m_serve = p; m_last = p;
          m_addr = a_q[p]; m_din = d_q[p]; m_wmask = m_q[p];
          break;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NP-1:0] eg, ep;
      eg = '0; ep = '0;
      if (m_serve >= 0) eg[m_serve] = 1'b1;
      if (m_done >= 0) begin eg[m_done] = 1'b1; ep[m_done] = 1'b1; end
      chk("model_grant", grant, eg);
      chk("model_mem_valid", mem_valid, m_serve >= 0);
      chk("model_p_ready", p_ready, ep);
      chk("model_mem_addr", mem_addr, m_addr);
      chk("model_mem_din", mem_din, m_din);
      chk("model_mem_wmask", mem_wmask, m_wmask);
      chk("model_p_dout", p_dout, m_dout);
    end
  end

  // Requester and controller behaviour knobs
  int            cnt = 0;
  int            lat_fixed = 0;
  bit            served = 0, spur_en = 0, force_rdy = 0, cont = 1, oneshot = 0, fix_en = 0;
  bit            fix_dout_en = 0;
  logic [31:0]   fix_dout = '0;
  logic [NP-1:0] req_en = '0;
  logic [AW-1:0] fa [NP];
  logic [31:0]   fd [NP];
  logic [3:0]    fm [NP];

  task automatic drive_cycle();
    mem_ready = 1'b0;
    if (mem_valid && !served) begin
      if (cnt == 0) cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 6));
      cnt--;
      if (cnt == 0) begin
        mem_ready = 1'b1;
        mem_dout  = fix_dout_en ? fix_dout : $urandom;
        served    = 1'b1;
      end
    end else if (!mem_valid) begin
      served = 1'b0;
      if (force_rdy || (spur_en && $urandom_range(0, 7) == 0)) begin
        mem_ready = 1'b1;
        mem_dout  = $urandom;
      end
      force_rdy = 1'b0;
    end
    for (int i = 0; i < NP; i++) begin
      if (p_ready[i]) begin
        p_valid[i] = 1'b0;
        if (oneshot) req_en[i] = 1'b0;
      end else if (!p_valid[i] && req_en[i] && (cont || $urandom_range(0, 2) == 0)) begin
        p_valid[i] = 1'b1;
        if (fix_en) begin
          a_q[i] = fa[i]; d_q[i] = fd[i]; m_q[i] = fm[i];
        end else begin
          a_q[i] = AW'($urandom);
          d_q[i] = $urandom;
          m_q[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; p_valid = '0; req_en = '0; mem_ready = 1'b0; cnt = 0; served = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int port, output int cyc);
    port = -1;
    cyc  = 0;
    for (int n = 0; n < 80; n++) begin
      step();
      cyc++;
      if (p_ready != '0) begin
        for (int i = 0; i < NP; i++) if (p_ready[i]) port = i;
        break;
      end
    end
    if (port < 0) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: got no p_ready, expected one within 80 cycles");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      step();
      if (p_valid == '0 && grant == '0 && !mem_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got busy arbiter, expected idle within 300 cycles");
    end
  endtask

  initial begin
    int port, cyc;
    p_valid = '0; mem_ready = 1'b0; mem_dout = '0;
    for (int i = 0; i < NP; i++) begin
      a_q[i] = '0; d_q[i] = '0; m_q[i] = '0; fa[i] = '0; fd[i] = '0; fm[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_grant", grant, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_p_ready", p_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_p_dout", p_dout, 0);

    // Fairness: all three re-request continuously
    fix_en = 0; cont = 1; oneshot = 0; req_en = '1;
    for (int k = 0; k < 6; k++) begin
      wait_ready(port, cyc);
      chk($sformatf("fair_order%0d", k), port, k % 3);
    end
    req_en = '0;
    drain();

    // Single read from port 1
    fix_en = 1; oneshot = 1; cont = 1;
    fa[1] = 25'h0000100; fd[1] = '0; fm[1] = 4'h0;
    lat_fixed = 10; fix_dout_en = 1; fix_dout = 32'hDEADBEEF;
    req_en = 3'b010;
    step();
    chk("rd_mv_pre", mem_valid, 0);
    step();
    chk("rd_mv", mem_valid, 1);
    chk("rd_grant", grant, 3'b010);
    chk("rd_addr", mem_addr, 25'h0000100);
    chk("rd_wmask", mem_wmask, 4'h0);
    wait_ready(port, cyc);
    chk("rd_latency", cyc, 10);
    chk("rd_p_ready", p_ready, 3'b010);
    chk("rd_p_dout", p_dout, 32'hDEADBEEF);
    step();
    chk("rd_p_ready_clr", p_ready, 0);
    chk("rd_grant_clr", grant, 0);
    chk("rd_p_dout_hold", p_dout, 32'hDEADBEEF);
    fix_dout_en = 0;

    // Byte write from port 2
    fa[2] = 25'h1ABCDE0; fd[2] = 32'h11223344; fm[2] = 4'b0100;
    lat_fixed = 5; req_en = 3'b100;
    step();
    for (int n = 0; n < 40; n++) begin
      step();
      if (p_ready != '0) break;
      if (mem_valid) begin
        chk("wr_addr", mem_addr, 25'h1ABCDE0);
        chk("wr_din", mem_din, 32'h11223344);
        chk("wr_wmask", mem_wmask, 4'b0100);
      end
    end
    chk("wr_p_ready", p_ready, 3'b100);
    step();
    chk("wr_p_ready_clr", p_ready, 0);

    // Wrap and skip: last is 2
    fa[0] = 25'h40; fd[0] = 32'hA5A5A5A5; fm[0] = 4'hF; fd[1] = 32'h5A5A5A5A;
    lat_fixed = 3; req_en = 3'b010;
    wait_ready(port, cyc);
    chk("wrap_first", port, 1);
    req_en = 3'b011;
    wait_ready(port, cyc);
    chk("wrap_second", port, 0);
    wait_ready(port, cyc);
    chk("wrap_third", port, 1);

    // Reset while BUSY on port 0
    lat_fixed = 20; req_en = 3'b001;
    step();
    step();
    chk("rm_mv", mem_valid, 1);
    chk("rm_grant", grant, 3'b001);
    step();
    step();
    do_reset();
    chk("rm_mv_after", mem_valid, 0);
    chk("rm_p_ready_after", p_ready, 0);
    chk("rm_grant_after", grant, 0);
    lat_fixed = 3; req_en = 3'b011;
    wait_ready(port, cyc);
    chk("rm_first", port, 0);
    wait_ready(port, cyc);
    chk("rm_second", port, 1);

    // Spurious mem_ready while idle
    step();
    force_rdy = 1;
    step();
    chk("sp_mem_ready_seen", mem_ready, 1);
    step();
    chk("sp_p_ready", p_ready, 0);
    chk("sp_mv", mem_valid, 0);
    chk("sp_grant", grant, 0);
    req_en = 3'b100;
    step();
    step();
    chk("sp_next_mv", mem_valid, 1);
    chk("sp_next_grant", grant, 3'b100);
    wait_ready(port, cyc);
    chk("sp_next_port", port, 2);

    // Random traffic
    oneshot = 0; cont = 0; fix_en = 0; lat_fixed = 0; spur_en = 1; req_en = '1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        req_en = '1;
      end
      step();
    end
    req_en = '0; spur_en = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
